// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed hex display scanner.
//
// Each digit gets a slot of DIGIT_CYCLES clocks. The first GAP_CYCLES clocks of
// a slot are dead time with all anodes off (GAP). The rest of the slot drives
// the selected anode low (ON). A new value is loaded into a pending register
// and only becomes visible at a frame boundary, so a frame never mixes digits
// from two different values. While enable is low the display is blank and any
// pending value is committed at once.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Digit 0 is never blanked.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        value_load,
  input  logic        enable,
  output logic [3:0]  hex_out,
  output logic [3:0]  an,
  output logic        value_pending,
  output logic        frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  localparam logic [0:0] ST_GAP = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [0:0]       state;
  logic [15:0]      disp_val;
  logic [15:0]      pending;

  logic             slot_end;
  logic             frame_wrap;
  logic             commit;
  logic [1:0]       idx_next;
  logic [15:0]      disp_next;
  logic [3:0]       hex_next;
  logic [3:0]       an_on;
  logic             digit_blank;

  // Next-slot decisions: slot/frame boundaries, value commit, next digit nibble.
  always_comb begin
    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    slot_end   = enable && (cnt == CNT_LAST);
    frame_wrap = slot_end && (idx == 2'd3);
    commit     = value_pending && (!enable || frame_wrap);
    disp_next  = commit ? pending : disp_val;

    if (!enable) begin
      idx_next = 2'd0;
    end else if (slot_end) begin
      idx_next = idx + 2'd1;
    end else begin
      idx_next = idx;
    end

    hex_next = disp_next[{idx_next, 2'b00} +: 4];
    an_on    = ~(4'b0001 << idx);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit above it are zero.
    digit_blank = (idx != 2'd0) && ((disp_val >> {idx, 2'b00}) == 16'h0000);
`else
    digit_blank = 1'b0;
`endif
  end

  // Value path: pending capture (last load wins) and commit into the display value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      disp_val      <= 16'h0000;
      pending       <= 16'h0000;
      value_pending <= 1'b0;
    end else begin
      disp_val <= disp_next;
      if (value_load) begin
        // A load on the commit cycle keeps the flag set for the new value.
        pending       <= value_in;
        value_pending <= 1'b1;
      end else if (commit) begin
        value_pending <= 1'b0;
      end
    end
  end

  // Scan timing: slot counter, digit index, GAP/ON state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      state      <= ST_GAP;
      an         <= 4'b1111;
      hex_out    <= 4'h0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      // Park at the start of digit 0 so re-enabling begins a full frame.
      cnt        <= '0;
      idx        <= idx_next;
      state      <= ST_GAP;
      an         <= 4'b1111;
      hex_out    <= hex_next;
      frame_done <= 1'b0;
    end else if (slot_end) begin
      cnt        <= '0;
      idx        <= idx_next;
      state      <= ST_GAP;
      an         <= 4'b1111;
      hex_out    <= hex_next;
      frame_done <= frame_wrap;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      frame_done <= 1'b0;
      if ((state == ST_GAP) && (cnt == GAP_LAST)) begin
        state <= ST_ON;
        an    <= digit_blank ? 4'b1111 : an_on;
      end
    end
  end

endmodule
